pc_sequencer: RTL and testbench

Parametrised program sequencer; successor to the fixed 7-bit saturating program counter.
- Generates the instruction fetch address and a fetch read-enable pulse.
- Supports sequential step, absolute jump, conditional branch, call/return through a hardware return stack, and explicit halt.
- Sits between the control FSM, which issues one op per step, and the instruction memory read port.

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/pc_return_stack.sv | 58 +++++
 rtl/pc_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program sequencer: op codes and FSM states.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_HALT   = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

endpackage

// File: rtl/pc_return_stack.sv
// Return-address LIFO for pc_sequencer. STACK_DEPTH entries of ADDR_W bits.
// dout shows the top entry combinationally; push and pop are never issued
// together by the sequencer. clr empties the stack and has priority.
module pc_return_stack #(
    parameter int ADDR_W      = 7,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               clr,
    input  logic [ADDR_W-1:0]                  din,
    output logic [ADDR_W-1:0]                  dout,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   level
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [LVL_W-1:0]  top;

    assign full  = (level == LVL_W'(STACK_DEPTH));
    assign empty = (level == '0);
    assign top   = level - LVL_W'(1);

    // Top-of-stack read; zero when empty so dout is never stale garbage.
    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem[top[IDX_W-1:0]];
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (clr) begin
            level <= '0;
        end else if (push && !full) begin
            level <= level + LVL_W'(1);
        end else if (pop && !empty) begin
            level <= level - LVL_W'(1);
        end
    end

    // Entry storage; written at the current level on push.
    always_ff @(posedge clk) begin
        if (!clr && push && !full) begin
            mem[level[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: fetch address and read strobe generation with
// sequential step, jump, conditional branch, call/return via a hardware
// return stack, halt and fault detection.
// Optional macro SEQ_WRAP_EN: SEQ / not-taken BRANCH at MAX_ADDR wraps to
// RESET_ADDR instead of saturating and halting.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int MAX_ADDR    = 127,
    parameter int RESET_ADDR  = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               step,
    input  logic [2:0]                         op,
    input  logic [ADDR_W-1:0]                  target,
    input  logic                               cond,
    input  logic                               restart,
    output logic [ADDR_W-1:0]                  pc_out,
    output logic                               pc_re_en,
    output logic                               halted,
    output logic                               fault,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);

    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W:0]   MAX_EXT = (ADDR_W + 1)'(MAX_ADDR);

    state_e            state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic              re_n;
    logic              boot, boot_n;

    logic              push, pop, clr;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_full, stk_empty;

    logic [ADDR_W:0]   pc_inc;
    logic              at_max;
    logic              target_bad, popped_bad;
    logic [ADDR_W-1:0] seq_pc;
    state_e            seq_state;
    logic              seq_re;

    pc_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (pc_inc[ADDR_W-1:0]),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .level (stack_level)
    );

    assign pc_inc     = {1'b0, pc_out} + (ADDR_W + 1)'(1);
    assign at_max     = (pc_inc > MAX_EXT);
    assign target_bad = ({1'b0, target}   > MAX_EXT);
    assign popped_bad = ({1'b0, stk_dout} > MAX_EXT);

    assign halted = (state == ST_HALTED);
    assign fault  = (state == ST_FAULT);

    // Outcome of a sequential advance, shared by SEQ and not-taken BRANCH.
    always_comb begin
`ifdef SEQ_WRAP_EN
        seq_pc    = at_max ? RST_PC : pc_inc[ADDR_W-1:0];
        seq_state = ST_RUN;
        seq_re    = 1'b1;
`else
        seq_pc    = at_max ? pc_out : pc_inc[ADDR_W-1:0];
        seq_state = at_max ? ST_HALTED : ST_RUN;
        seq_re    = !at_max;
`endif
    end

    // Next-state, next-pc, strobe and stack control.
    always_comb begin
        state_n = state;
        pc_n    = pc_out;
        re_n    = 1'b0;
        boot_n  = boot;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        if (restart) begin
            state_n = ST_RUN;
            pc_n    = RST_PC;
            re_n    = 1'b1;
            clr     = 1'b1;
            boot_n  = 1'b0;
        end else if (boot) begin
            re_n   = 1'b1;
            boot_n = 1'b0;
        end else if (step && state == ST_RUN) begin
            case (op)
                OP_SEQ: begin
                    pc_n    = seq_pc;
                    state_n = seq_state;
                    re_n    = seq_re;
                end
                OP_JUMP: begin
                    if (target_bad) begin
                        state_n = ST_FAULT;
                    end else begin
                        pc_n = target;
                        re_n = 1'b1;
                    end
                end
                OP_BRANCH: begin
                    if (!cond) begin
                        pc_n    = seq_pc;
                        state_n = seq_state;
                        re_n    = seq_re;
                    end else if (target_bad) begin
                        state_n = ST_FAULT;
                    end else begin
                        pc_n = target;
                        re_n = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (stk_full || target_bad) begin
                        state_n = ST_FAULT;
                    end else begin
                        push = 1'b1;
                        pc_n = target;
                        re_n = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stk_empty || popped_bad) begin
                        state_n = ST_FAULT;
                    end else begin
                        pop  = 1'b1;
                        pc_n = stk_dout;
                        re_n = 1'b1;
                    end
                end
                OP_HALT: begin
                    state_n = ST_HALTED;
                end
                default: begin
                    state_n = ST_FAULT;
                end
            endcase
        end
    end

    // Registered state, pc, read strobe and boot flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pc_out   <= RST_PC;
            pc_re_en <= 1'b0;
            boot     <= 1'b1;
        end else begin
            state    <= state_n;
            pc_out   <= pc_n;
            pc_re_en <= re_n;
            boot     <= boot_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. A second instance with
// MAX_ADDR=100 exercises the out-of-range target fault.
module tb_pc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       step, cond, restart;
    logic [2:0] op;
    logic [6:0] target;
    logic [6:0] pc_out;
    logic       pc_re_en, halted, fault;
    logic [2:0] stack_level;

    logic       step2, cond2, restart2;
    logic [2:0] op2;
    logic [6:0] target2;
    logic [6:0] pc_out2;
    logic       pc_re_en2, halted2, fault2;
    logic [2:0] stack_level2;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (step),
        .op          (op),
        .target      (target),
        .cond        (cond),
        .restart     (restart),
        .pc_out      (pc_out),
        .pc_re_en    (pc_re_en),
        .halted      (halted),
        .fault       (fault),
        .stack_level (stack_level)
    );

    pc_sequencer #(
        .MAX_ADDR (100)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (step2),
        .op          (op2),
        .target      (target2),
        .cond        (cond2),
        .restart     (restart2),
        .pc_out      (pc_out2),
        .pc_re_en    (pc_re_en2),
        .halted      (halted2),
        .fault       (fault2),
        .stack_level (stack_level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input int e_pc, input int e_re,
                            input int e_halt, input int e_fault, input int e_lvl);
        chk({tag, ".pc"},     32'(pc_out),      32'(e_pc));
        chk({tag, ".re"},     32'(pc_re_en),    32'(e_re));
        chk({tag, ".halted"}, 32'(halted),      32'(e_halt));
        chk({tag, ".fault"},  32'(fault),       32'(e_fault));
        chk({tag, ".level"},  32'(stack_level), 32'(e_lvl));
    endtask

    // Called #1 after a rising edge; applies an op for exactly one edge.
    task automatic do_op(input logic [2:0] o, input logic [6:0] t, input logic c);
        step = 1'b1; op = o; target = t; cond = c;
        @(posedge clk); #1;
        step = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic do_op2(input logic [2:0] o, input logic [6:0] t);
        step2 = 1'b1; op2 = o; target2 = t;
        @(posedge clk); #1;
        step2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; step = 1'b0; op = 3'd0; target = '0; cond = 1'b0; restart = 1'b0;
        step2 = 1'b0; op2 = 3'd0; target2 = '0; cond2 = 1'b0; restart2 = 1'b0;
        #1;
        chk_main("reset", 0, 0, 0, 0, 0);

        // Boot pulse: exactly one cycle of read strobe after release.
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_main("boot1", 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk_main("boot2", 0, 0, 0, 0, 0);

        // Walk to the top of the address space.
        for (int i = 0; i < 127; i++) do_op(3'd0, '0, 1'b0);
        chk_main("seq127", 127, 1, 0, 0, 0);
        do_op(3'd0, '0, 1'b0);
`ifdef SEQ_WRAP_EN
        chk_main("seq128_wrap", 0, 1, 0, 0, 0);
`else
        chk_main("seq128_sat", 127, 0, 1, 0, 0);
        do_op(3'd0, '0, 1'b0);
        chk_main("halted_ignores_step", 127, 0, 1, 0, 0);
`endif

        do_restart();
        chk_main("restart1", 0, 1, 0, 0, 0);

        // Call / return nesting.
        do_op(3'd1, 7'd10, 1'b0);
        chk_main("jump10", 10, 1, 0, 0, 0);
        do_op(3'd3, 7'd40, 1'b0);
        chk_main("call40", 40, 1, 0, 0, 1);
        do_op(3'd3, 7'd60, 1'b0);
        chk_main("call60", 60, 1, 0, 0, 2);
        do_op(3'd4, '0, 1'b0);
        chk_main("ret1", 41, 1, 0, 0, 1);
        do_op(3'd4, '0, 1'b0);
        chk_main("ret2", 11, 1, 0, 0, 0);

        // Overflow the four-entry stack.
        do_op(3'd3, 7'd20, 1'b0);
        do_op(3'd3, 7'd30, 1'b0);
        do_op(3'd3, 7'd40, 1'b0);
        do_op(3'd3, 7'd50, 1'b0);
        chk_main("call4", 50, 1, 0, 0, 4);
        do_op(3'd3, 7'd70, 1'b0);
        chk_main("call5_overflow", 50, 0, 0, 1, 4);
        do_op(3'd0, '0, 1'b0);
        chk_main("fault_ignores_step", 50, 0, 0, 1, 4);
        do_restart();
        chk_main("restart2", 0, 1, 0, 0, 0);

        // Branch not taken / taken.
        do_op(3'd1, 7'd5, 1'b0);
        do_op(3'd2, 7'd50, 1'b0);
        chk_main("branch_nt", 6, 1, 0, 0, 0);
        do_op(3'd2, 7'd50, 1'b1);
        chk_main("branch_t", 50, 1, 0, 0, 0);

        // Explicit halt.
        do_op(3'd5, '0, 1'b0);
        chk_main("halt", 50, 0, 1, 0, 0);
        do_restart();
        chk_main("restart3", 0, 1, 0, 0, 0);

        // Return with empty stack.
        do_op(3'd4, '0, 1'b0);
        chk_main("ret_empty", 0, 0, 0, 1, 0);
        do_restart();

        // Reserved op.
        do_op(3'd1, 7'd9, 1'b0);
        do_op(3'd6, 7'd33, 1'b0);
        chk_main("reserved_op", 9, 0, 0, 1, 0);
        do_restart();
        chk_main("restart4", 0, 1, 0, 0, 0);

        // Out-of-range jump on the MAX_ADDR=100 instance.
        do_op2(3'd1, 7'd100);
        chk("jmp100.pc",    32'(pc_out2),   32'd100);
        chk("jmp100.fault", 32'(fault2),    32'd0);
        do_op2(3'd1, 7'd120);
        chk("jmp120.pc",    32'(pc_out2),   32'd100);
        chk("jmp120.fault", 32'(fault2),    32'd1);
        chk("jmp120.re",    32'(pc_re_en2), 32'd0);

        // Asynchronous reset in the middle of a call stream.
        do_op(3'd3, 7'd20, 1'b0);
        do_op(3'd3, 7'd30, 1'b0);
        chk_main("precall", 30, 1, 0, 0, 2);
        step = 1'b1; op = 3'd3; target = 7'd40;
        #2 rst_n = 1'b0;
        #1;
        chk_main("async_reset", 0, 0, 0, 0, 0);
        chk("async_reset.fault2", 32'(fault2), 32'd0);
        @(posedge clk); #1;
        chk_main("held_reset", 0, 0, 0, 0, 0);

        // Step offered during the boot edge is dropped.
        step = 1'b1; op = 3'd0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        chk_main("boot_wins", 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk_main("boot_after", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
